csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
- Sequencer and arbiter for the single CSR-file write port.
- Shares that port between ordinary CSR-instruction writes (the csr_wen/csr_wdata produced by the CSR execute unit) and machine-mode trap entry / mret return.
- Trap entry and return each take a fixed multi-cycle sequence: one CSR write per cycle, then a PC redirect with pipeline flush.
- Sits between the execute stage, the CSR register file and the PC/fetch logic.

Parameters:
XLEN, 32, data and address width of CSR values and PC
IRQ_CODE, 11, mcause exception code used for the external interrupt

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
inst_csr_wen  input  1  CSR-instruction write request from execute
inst_csr_waddr  input  12  CSR address of instruction write
inst_csr_wdata  input  XLEN  data of instruction write
trap_req  input  1  synchronous exception from execute
trap_cause  input  XLEN  mcause value for exception (bit XLEN-1 = 0)
trap_pc  input  XLEN  PC of faulting instruction
trap_tval  input  XLEN  mtval value
mret_req  input  1  mret executing
irq_pending  input  1  external interrupt pending (level)
irq_pc  input  XLEN  PC of next instruction to retire, saved on interrupt
mstatus  input  XLEN  current mstatus from CSR file
mtvec  input  XLEN  current mtvec from CSR file
mepc  input  XLEN  current mepc from CSR file
csr_we  output  1  CSR-file write enable
csr_waddr  output  12  CSR-file write address
csr_wdata  output  XLEN  CSR-file write data
busy  output  1  sequence in progress; pipeline must stall
trap_ack  output  1  one-cycle pulse, trap/irq/mret accepted
redirect_valid  output  1  one-cycle pulse, PC redirect + flush
redirect_pc  output  XLEN  target PC, valid with redirect_valid

Behaviour:
- Reset: state IDLE; all captured registers and all outputs 0.
- Reset asserted mid-sequence aborts it: no further CSR writes and no redirect.
- csr_we, csr_waddr and csr_wdata are combinational from state and captured registers. busy, trap_ack, redirect_valid and redirect_pc are registered.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP.

IDLE arbitration (priority high to low):
- trap_req: capture trap_pc, trap_cause, trap_tval; then go to T_EPC.
- mret_req: go to R_STATUS.
- irq_pending && mstatus[3]: capture pc = irq_pc, cause = {1'b1, IRQ_CODE zero-extended}, tval = 0; then go to T_EPC.
- For all three accepted events: trap_ack=1 next cycle and busy=1 from next cycle until the redirect cycle inclusive.
- Otherwise: pass inst_csr_* straight to csr_we/waddr/wdata in the same cycle.
- An instruction write in the same cycle as an accepted event is dropped (the trapping instruction does not commit).
- Outside IDLE, inst_csr_wen is ignored.

Trap sequence, one write per state:
- T_EPC: write 0x341 with {pc[XLEN-1:2], 2'b00}.
- T_CAUSE: write 0x342 with cause.
- T_TVAL: write 0x343 with tval.
- T_STATUS: write 0x300 with mstatus, modified as MPIE(bit7)=MIE(bit3), MIE=0, MPP(bits12:11)=2'b11; other bits unchanged.
- T_JUMP: no write. redirect_valid=1 next cycle; go to IDLE.
  - Target = {mtvec[XLEN-1:2], 2'b00} if mtvec[1:0]!=2'b01 or cause[XLEN-1]==0.
  - Otherwise target = base + (cause[XLEN-2:0] << 2), truncated to XLEN (wrap-around allowed).
- Trap latency: accept cycle N, writes in N+1..N+4, redirect_valid pulse in N+6.

Mret sequence:
- R_STATUS: write 0x300 with mstatus, modified as MIE=MPIE, MPIE=1, MPP=2'b11.
- R_JUMP: redirect_pc = {mepc[XLEN-1:2], 2'b00}; redirect_valid next cycle; go to IDLE.
- Mret latency: accept N, write N+1, redirect N+3.

Boundary cases:
- Events arriving while not in IDLE are ignored; sources hold requests until trap_ack.
- irq_pending is sampled only in IDLE, so an interrupt cannot nest into a trap sequence.
- Because T_STATUS clears MIE, a still-pending interrupt is not taken until mret restores MIE.
- Back-to-back: a new event may be accepted in the cycle immediately after redirect_valid.

Test Plan:
- Pass-through: IDLE, inst_csr_wen=1, waddr=0x305, wdata=0x80000100 -> same-cycle csr_we=1, waddr=0x305, wdata=0x80000100; busy=0.
- Exception: trap_req, pc=0x1006, cause=2, tval=0xDEAD, mstatus=0x8, mtvec=0x200 -> writes 0x341=0x1004, 0x342=2, 0x343=0xDEAD, 0x300=0x1880 on consecutive cycles; redirect_pc=0x200 at N+6.
- Vectored irq: mtvec=0x201, mstatus=0x8, irq_pending=1, irq_pc=0x3000 -> mcause=0x8000000B, mepc=0x3000, redirect_pc=0x22C.
- Masked/priority: mstatus=0 with irq_pending -> no ack. Simultaneous trap_req+mret_req+irq+inst write -> exception sequence only, inst write dropped.
- Mret: mstatus=0x1880, mepc=0x1004 -> write 0x300=0x1888; redirect_pc=0x1004 at N+3.
- Reset mid-trap: assert rst during T_CAUSE -> csr_we=0 immediately, no redirect, busy=0; after release a fresh trap_req completes normally.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Arbitrates the single CSR-file write port between CSR instructions and the
// machine-mode trap-entry / mret sequences, then issues the PC redirect.
module csr_trap_ctrl #(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_csr_wen,
    input  logic [11:0]     inst_csr_waddr,
    input  logic [XLEN-1:0] inst_csr_wdata,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    input  logic            irq_pending,
    input  logic [XLEN-1:0] irq_pc,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            busy,
    output logic            trap_ack,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_T_EPC    = 3'd1;
    localparam logic [2:0] S_T_CAUSE  = 3'd2;
    localparam logic [2:0] S_T_TVAL   = 3'd3;
    localparam logic [2:0] S_T_STATUS = 3'd4;
    localparam logic [2:0] S_T_JUMP   = 3'd5;
    localparam logic [2:0] S_R_STATUS = 3'd6;
    localparam logic [2:0] S_R_JUMP   = 3'd7;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, (XLEN-1)'(IRQ_CODE)};

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            accept;

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Return: MIE <= MPIE, MPIE <= 1, MPP <= M.
    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                    input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = tvec & ALIGN_MASK;
        if (tvec[1:0] == 2'b01 && cause[XLEN-1])
            return base + {cause[XLEN-3:0], 2'b00};
        return base;
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        tval_d    = tval_q;
        rpc_d     = rpc_q;
        rv_d      = 1'b0;
        accept    = 1'b0;
        csr_we    = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = '0;
        case (state_q)
            S_IDLE: begin
                // The redirect/flush cycle still counts as busy; nothing is taken until it is over.
                if (!rv_q) begin
                    if (trap_req) begin
                        accept  = 1'b1;
                        pc_d    = trap_pc;
                        cause_d = trap_cause;
                        tval_d  = trap_tval;
                        state_d = S_T_EPC;
                    end else if (mret_req) begin
                        accept  = 1'b1;
                        state_d = S_R_STATUS;
                    end else if (irq_pending && mstatus[3]) begin
                        accept  = 1'b1;
                        pc_d    = irq_pc;
                        cause_d = IRQ_CAUSE;
                        tval_d  = '0;
                        state_d = S_T_EPC;
                    end else begin
                        csr_we    = inst_csr_wen;
                        csr_waddr = inst_csr_waddr;
                        csr_wdata = inst_csr_wdata;
                    end
                end
            end
            S_T_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h341;
                csr_wdata = pc_q & ALIGN_MASK;
                state_d   = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h342;
                csr_wdata = cause_q;
                state_d   = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h343;
                csr_wdata = tval_q;
                state_d   = S_T_STATUS;
            end
            S_T_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = trap_status(mstatus);
                state_d   = S_T_JUMP;
            end
            S_T_JUMP: begin
                rv_d    = 1'b1;
                rpc_d   = trap_target(mtvec, cause_q);
                state_d = S_IDLE;
            end
            S_R_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = mret_status(mstatus);
                state_d   = S_R_JUMP;
            end
            S_R_JUMP: begin
                rv_d    = 1'b1;
                rpc_d   = mepc & ALIGN_MASK;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ack_d  = accept;
        busy_d = accept || (state_q != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
        end
    end

    assign busy           = busy_q;
    assign trap_ack       = ack_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: pass-through, exception, vectored irq,
// masking/priority, mret, back-to-back acceptance and reset abort.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_csr_wen;
    logic [11:0] inst_csr_waddr;
    logic [31:0] inst_csr_wdata;
    logic        trap_req;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret_req, irq_pending;
    logic [31:0] irq_pc, mstatus, mtvec, mepc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        busy, trap_ack, redirect_valid;
    logic [31:0] redirect_pc;

    int nvec = 0;
    int nerr = 0;

    csr_trap_ctrl #(.XLEN(32), .IRQ_CODE(11)) dut (
        .clk(clk), .rst(rst),
        .inst_csr_wen(inst_csr_wen), .inst_csr_waddr(inst_csr_waddr), .inst_csr_wdata(inst_csr_wdata),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_req(mret_req), .irq_pending(irq_pending), .irq_pc(irq_pc),
        .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .busy(busy), .trap_ack(trap_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
        chk({tag, "_we"}, {31'd0, csr_we}, 32'd1);
        chk({tag, "_addr"}, {20'd0, csr_waddr}, {20'd0, a});
        chk({tag, "_data"}, csr_wdata, d);
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic a, input logic r);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_ack"}, {31'd0, trap_ack}, {31'd0, a});
        chk({tag, "_rv"}, {31'd0, redirect_valid}, {31'd0, r});
    endtask

    initial begin
        rst = 1'b1;
        inst_csr_wen = 0; inst_csr_waddr = 0; inst_csr_wdata = 0;
        trap_req = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
        mret_req = 0; irq_pending = 0; irq_pc = 0;
        mstatus = 0; mtvec = 0; mepc = 0;
        cyc(); cyc();
        chk_ctl("rst", 0, 0, 0);
        chk("rst_we", {31'd0, csr_we}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        rst = 1'b0;
        cyc();

        // Pass-through
        inst_csr_wen = 1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h8000_0100;
        #1;
        chk_wr("pt", 12'h305, 32'h8000_0100);
        chk("pt_busy", {31'd0, busy}, 32'd0);
        cyc();
        inst_csr_wen = 0;

        // Exception with simultaneous mret, irq and instruction write
        trap_req = 1; trap_pc = 32'h1006; trap_cause = 32'd2; trap_tval = 32'hDEAD;
        mret_req = 1; irq_pending = 1; irq_pc = 32'h5000;
        inst_csr_wen = 1; inst_csr_waddr = 12'h305; inst_csr_wdata = 32'h1234;
        mstatus = 32'h8; mtvec = 32'h200;
        #1;
        chk("ex_drop_we", {31'd0, csr_we}, 32'd0);
        cyc();
        trap_req = 0; mret_req = 0; irq_pending = 0; inst_csr_wen = 1;
        #1;
        chk_ctl("ex_n1", 1, 1, 0);
        chk_wr("ex_epc", 12'h341, 32'h1004);
        cyc(); #1;
        chk_ctl("ex_n2", 1, 0, 0);
        chk_wr("ex_cause", 12'h342, 32'd2);
        cyc(); #1;
        chk_wr("ex_tval", 12'h343, 32'hDEAD);
        cyc(); #1;
        chk_wr("ex_status", 12'h300, 32'h1880);
        cyc(); #1;
        chk("ex_jump_we", {31'd0, csr_we}, 32'd0);
        chk_ctl("ex_n5", 1, 0, 0);
        cyc(); #1;
        chk_ctl("ex_n6", 1, 0, 1);
        chk("ex_rpc", redirect_pc, 32'h200);
        cyc(); #1;
        inst_csr_wen = 0;
        chk_ctl("ex_n7", 0, 0, 0);

        // Masked interrupt
        mstatus = 32'h0; irq_pending = 1; irq_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk_ctl("mask", 0, 0, 0);
        end

        // Vectored interrupt
        mstatus = 32'h8; mtvec = 32'h201;
        cyc();
        irq_pending = 0;
        #1;
        chk_ctl("irq_n1", 1, 1, 0);
        chk_wr("irq_epc", 12'h341, 32'h3000);
        cyc(); #1;
        chk_wr("irq_cause", 12'h342, 32'h8000_000B);
        cyc(); #1;
        chk_wr("irq_tval", 12'h343, 32'h0);
        cyc(); #1;
        chk_wr("irq_status", 12'h300, 32'h1880);
        cyc(); cyc(); #1;
        chk_ctl("irq_n6", 1, 0, 1);
        chk("irq_rpc", redirect_pc, 32'h22C);
        cyc();

        // Mret
        mstatus = 32'h1880; mepc = 32'h1004; mret_req = 1;
        cyc();
        mret_req = 0;
        #1;
        chk_ctl("mret_n1", 1, 1, 0);
        chk_wr("mret_status", 12'h300, 32'h1888);
        cyc(); #1;
        chk("mret_n2_we", {31'd0, csr_we}, 32'd0);
        chk_ctl("mret_n2", 1, 0, 0);
        cyc();
        // Request raised during the redirect cycle; accepted in the following cycle
        trap_req = 1; trap_pc = 32'h2000; trap_cause = 32'd7; trap_tval = 32'h0;
        #1;
        chk_ctl("mret_n3", 1, 0, 1);
        chk("mret_rpc", redirect_pc, 32'h1004);
        cyc(); #1;
        chk_ctl("b2b_n4", 0, 0, 0);
        cyc();
        trap_req = 0;
        #1;
        chk_ctl("b2b_ack", 1, 1, 0);
        chk_wr("b2b_epc", 12'h341, 32'h2000);

        // Reset during T_CAUSE
        cyc();
        rst = 1;
        #1;
        chk("rst_mid_we", {31'd0, csr_we}, 32'd0);
        chk_ctl("rst_mid", 0, 0, 0);
        chk("rst_mid_rpc", redirect_pc, 32'd0);
        cyc(); cyc();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(); #1;
            chk_ctl("rst_after", 0, 0, 0);
        end

        // Fresh trap after reset
        mstatus = 32'h0; mtvec = 32'h100;
        trap_req = 1; trap_pc = 32'h44; trap_cause = 32'd5; trap_tval = 32'h77;
        cyc();
        trap_req = 0;
        #1;
        chk_ctl("fr_n1", 1, 1, 0);
        chk_wr("fr_epc", 12'h341, 32'h44);
        cyc(); #1;
        chk_wr("fr_cause", 12'h342, 32'd5);
        cyc(); #1;
        chk_wr("fr_tval", 12'h343, 32'h77);
        cyc(); #1;
        chk_wr("fr_status", 12'h300, 32'h1800);
        cyc(); cyc(); #1;
        chk_ctl("fr_n6", 1, 0, 1);
        chk("fr_rpc", redirect_pc, 32'h100);
        cyc(); #1;
        chk_ctl("fr_n7", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
